jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven controller for a WIDTH-bit bank of JK flip-flops. It accepts set, clear, toggle and multi-cycle count commands over a valid/ready handshake. It computes the per-bit J/K drive each cycle and holds the bank state using JK next-state semantics. It sits between a command source (test sequencer or CPU-side register) and the JK storage cells, and is the single owner of their J/K inputs.

## Interface
Parameters:
- WIDTH, 4: number of JK bits in the bank.
- CNT_W, 8: width of the count-length field.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  0 HOLD, 1 SET, 2 CLEAR, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN, 6–7 reserved.
- cmd_mask  input  WIDTH  bits affected by SET/CLEAR/TOGGLE; ignored by COUNT ops.
- cmd_len  input  CNT_W  number of count steps for COUNT ops; ignored otherwise.
- j  output  WIDTH  J drive applied at the next edge.
- k  output  WIDTH  K drive applied at the next edge.
- q  output  WIDTH  bank state.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

## Operation
- Bank update every edge: q <= (j & ~q) | (~k & q).
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1, j=k=0. On cmd_valid & cmd_ready at an edge:
  - latch op, mask and len;
  - load remaining-count rem = len;
  - go to EXEC.
- EXEC: j/k are combinational from the latched op and current q.
  - HOLD or reserved: j=k=0.
  - SET: j=mask, k=0.
  - CLEAR: j=0, k=mask.
  - TOGGLE: j=k=mask.
  - COUNT_UP: j[i]=k[i]=&q[i-1:0], with bit 0 always 1.
  - COUNT_DOWN: j[i]=k[i]=&~q[i-1:0], with bit 0 always 1.
  - COUNT with len=0: j=k=0 for its single EXEC cycle.
- EXEC exit:
  - Non-COUNT ops, and COUNT with len≤1: leave EXEC after one cycle.
  - COUNT with len>1: stay in EXEC, rem decrements each edge, leave on the edge where rem==1.
- DONE: done=1, j=k=0, cmd_ready=0. Always go to IDLE at the next edge.
- Arithmetic: counting wraps modulo 2^WIDTH (1111→0000 up, 0000→1111 down). rem is CNT_W bits. Maximum len is 2^CNT_W−1 steps.
- Outputs:
  - busy = (state != IDLE).
  - cmd_ready = (state == IDLE).
- cmd_valid while busy is ignored. The command is not consumed, and the source must hold it until cmd_ready.
- Reset (asynchronous, any state, including mid-COUNT):
  - q=0, state=IDLE, rem=0, latched op/mask/len=0;
  - outputs j=0, k=0, busy=0, done=0, cmd_ready=1.
  - The aborted command produces no done pulse.

## Timing
- Acceptance edge A: state becomes EXEC, and j/k become valid in the cycle after A.
- Single-step ops: q shows the new value after edge A+1. done is high in cycle A+1..A+2. cmd_ready returns after edge A+2.
- COUNT len=N≥1: q takes N steps, one per edge A+1..A+N. done is high after edge A+N for one cycle. Next acceptance is possible at edge A+N+2.
- Throughput: one command per 3 cycles minimum.
- j/k are combinational from registered state and q only. There is no combinational path from cmd_* to j/k/q.
- done is never high in two consecutive cycles.

## Test plan
- Reset, then SET mask=0101 → q=0000 until edge A+1, then q=0101; done pulses exactly one cycle; cmd_ready low for 2 cycles.
- From 0101, TOGGLE mask=1111 → q=1010. Then CLEAR mask=1000 → q=0010. Then HOLD → q=0010 and done still pulses.
- From 0000, COUNT_UP len=20 → q steps 0001…1111, 0000…0100. Final q=0100; busy high for 21 cycles; j=k=1111 observed on the 1111→0000 step.
- From 0000, COUNT_DOWN len=3 → q=1111, 1110, 1101. done follows the 3rd step.
- Hold cmd_valid with a SET during a COUNT → no acceptance until cmd_ready=1, then the SET executes once. COUNT len=0 → q unchanged, done after 2 cycles. op=6 → q unchanged, done pulses.
- Assert rst mid-COUNT_UP (q=0011) → q=0, busy=0, cmd_ready=1 immediately, without waiting for a clock edge. No done pulse. After release, a new SET completes normally.

Source files
------------

// File: rtl/jk_bank_ctrl_if.sv
// Command channel for jk_bank_ctrl: a valid/ready handshake carrying op, mask and count length.
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_len;

  modport master (output cmd_valid, cmd_op, cmd_mask, cmd_len, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command-driven owner of a bank of JK flip-flops: decodes set/clear/toggle/count commands
// into per-bit J/K drive and holds the bank state with JK next-state semantics.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_SET    = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_UP     = 3'd4,
    OP_DOWN   = 3'd5,
    OP_RSV6   = 3'd6,
    OP_RSV7   = 3'd7
  } op_e;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rem;
  logic             is_count;

  assign is_count      = (op_q == OP_UP) || (op_q == OP_DOWN);
  assign busy          = (state != S_IDLE);
  assign cmd.cmd_ready = (state == S_IDLE);
  assign done          = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_HOLD;
      mask_q <= '0;
      len_q  <= '0;
      rem    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            state  <= S_EXEC;
            op_q   <= op_e'(cmd.cmd_op);
            mask_q <= cmd.cmd_mask;
            len_q  <= cmd.cmd_len;
            rem    <= cmd.cmd_len;
          end
        end
        S_EXEC: begin
          // A count keeps stepping until the edge on which only one step remains.
          if (is_count && rem > CNT_W'(1)) begin
            rem <= rem - CNT_W'(1);
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic carry;
    j     = '0;
    k     = '0;
    carry = 1'b1;
    if (state == S_EXEC) begin
      case (op_q)
        OP_SET:    j = mask_q;
        OP_CLEAR:  k = mask_q;
        OP_TOGGLE: begin
          j = mask_q;
          k = mask_q;
        end
        OP_UP, OP_DOWN: begin
          // Ripple enable: bit i toggles when all lower bits are 1 (up) or all 0 (down).
          if (len_q != '0) begin
            for (int i = 0; i < WIDTH; i++) begin
              j[i]  = carry;
              k[i]  = carry;
              carry = carry & ((op_q == OP_UP) ? q[i] : ~q[i]);
            end
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Scoreboard bench for jk_bank_ctrl: stimulus pushes the expected bank value per command,
// a monitor pops and compares it on every done pulse.
module tb_jk_bank_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] j, k, q;
  logic         busy, done;

  jk_bank_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cmd_if ();

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .j    (j),
    .k    (k),
    .q    (q),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W-1:0] sb[$];
  logic         prev_done = 1'b0;
  logic         saw_wrap;
  int           cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command; returns #1 after the acceptance edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] mask,
                      input logic [CW-1:0] len, input logic [W-1:0] exp_q);
    int waited = 0;
    sb.push_back(exp_q);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_mask  = mask;
    cmd_if.cmd_len   = len;
    while (!cmd_if.cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_timeout", {31'd0, cmd_if.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (busy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: pops one expected value per done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (done) begin
          check("done_back_to_back", {31'd0, prev_done}, 32'd0);
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_unexpected_done: got done with q=%0h, expected no pulse", q);
          end else begin
            check("sb_q", {28'd0, q}, {28'd0, sb.pop_front()});
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_mask  = '0;
    cmd_if.cmd_len   = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_q", {28'd0, q}, 32'd0);
    check("rst_jk", {24'd0, j, k}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    rst = 1'b0;

    // SET 0101 with cycle-accurate timing.
    send(3'd1, 4'b0101, 8'd0, 4'b0101);
    check("set_q_before", {28'd0, q}, 32'h0);
    check("set_j", {28'd0, j}, 32'h5);
    check("set_k", {28'd0, k}, 32'h0);
    check("set_ready_a", {31'd0, cmd_if.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("set_q_after", {28'd0, q}, 32'h5);
    check("set_done", {31'd0, done}, 32'd1);
    check("set_ready_a1", {31'd0, cmd_if.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("set_done_off", {31'd0, done}, 32'd0);
    check("set_ready_a2", {31'd0, cmd_if.cmd_ready}, 32'd1);

    send(3'd3, 4'b1111, 8'd0, 4'b1010);  // TOGGLE
    send(3'd2, 4'b1000, 8'd0, 4'b0010);  // CLEAR
    send(3'd0, 4'b1111, 8'd0, 4'b0010);  // HOLD
    send(3'd2, 4'b1111, 8'd0, 4'b0000);  // CLEAR all
    wait_idle();

    // COUNT_UP 20 from 0000: wraps once, ends at 0100, busy 21 cycles.
    saw_wrap = 1'b0;
    send(3'd4, 4'b0000, 8'd20, 4'b0100);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (q == 4'b1111 && j == 4'b1111 && k == 4'b1111) saw_wrap = 1'b1;
      cyc++;
      @(posedge clk); #1;
    end
    check("up20_busy_cycles", cyc, 32'd21);
    check("up20_wrap_jk", {31'd0, saw_wrap}, 32'd1);

    // COUNT_DOWN 3 from 0000: 1111, 1110, 1101.
    send(3'd2, 4'b1111, 8'd0, 4'b0000);
    wait_idle();
    send(3'd5, 4'b0000, 8'd3, 4'b1101);
    @(posedge clk); #1;
    check("dn_step1", {28'd0, q}, 32'hF);
    @(posedge clk); #1;
    check("dn_step2", {28'd0, q}, 32'hE);
    @(posedge clk); #1;
    check("dn_step3", {28'd0, q}, 32'hD);
    check("dn_done", {31'd0, done}, 32'd1);
    wait_idle();

    // SET held while COUNT_UP 5 runs: 1101+5 = 0010, then SET 1000 -> 1010.
    send(3'd4, 4'b1111, 8'd5, 4'b0010);
    send(3'd1, 4'b1000, 8'd0, 4'b1010);
    check("held_set_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // COUNT len=0: unchanged, done in cycle after the single EXEC.
    send(3'd4, 4'b0000, 8'd0, 4'b1010);
    check("len0_jk", {24'd0, j, k}, 32'd0);
    @(posedge clk); #1;
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_q", {28'd0, q}, 32'hA);
    wait_idle();

    send(3'd6, 4'b1111, 8'd9, 4'b1010);  // reserved op
    send(3'd2, 4'b1111, 8'd0, 4'b0000);
    wait_idle();

    // Asynchronous reset mid-count.
    send(3'd4, 4'b0000, 8'd10, 4'b1010);
    cyc = 0;
    while (q != 4'b0011 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_q", {28'd0, q}, 32'h3);
    #1 rst = 1'b1;
    #1;
    check("arst_q", {28'd0, q}, 32'h0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("arst_jk", {24'd0, j, k}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(3'd1, 4'b0110, 8'd0, 4'b0110);
    wait_idle();
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
